// File: rtl/vid_sram_dump_ctrl.sv
// Read-out sequencer: walks the enabled vid SRAM banks address-major and streams one word per handshake.
// Optional VID_DUMP_CHKSUM_EN adds an XOR checksum of every accepted word on port chksum.
module vid_sram_dump_ctrl #(
    parameter int K              = 16,
    parameter int Q              = 16,
    parameter int VID_BW         = 16,
    parameter int VID_ADDR_SPACE = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [K-1:0]                bank_mask,
    output logic [VID_ADDR_SPACE-1:0]   vid_sram_raddr,
    input  logic [K*Q*VID_BW-1:0]       rdata_all,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [Q*VID_BW-1:0]         out_data,
    output logic [3:0]                  out_bank,
    output logic [VID_ADDR_SPACE-1:0]   out_addr,
    output logic                        busy,
    output logic                        done
`ifdef VID_DUMP_CHKSUM_EN
    ,
    output logic [Q*VID_BW-1:0]         chksum
`endif
);

    localparam int WORD_W = Q * VID_BW;
    localparam logic [VID_ADDR_SPACE-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                      r_state, w_state_next;
    logic [VID_ADDR_SPACE-1:0]   r_addr, w_addr_next;
    logic [3:0]                  r_bank, w_bank_next;
    logic [K-1:0]                r_mask, w_mask_next;

    logic [WORD_W-1:0]           w_words [K];
    logic [K-1:0]                w_above;
    logic [3:0]                  w_low_bank;
    logic [3:0]                  w_next_bank;
    logic                        w_has_next;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_bank
            assign w_words[gi] = rdata_all[gi*WORD_W +: WORD_W];
            // Enabled banks strictly after the one currently on the output.
            assign w_above[gi] = r_mask[gi] && (r_bank < 4'(gi));
        end
    endgenerate

    always_comb begin
        w_low_bank  = '0;
        w_next_bank = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (r_mask[i])  w_low_bank  = 4'(i);
            if (w_above[i]) w_next_bank = 4'(i);
        end
    end

    assign w_has_next = |w_above;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_bank  <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_bank  <= w_bank_next;
            r_mask  <= w_mask_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_bank_next  = r_bank;
        w_mask_next  = r_mask;
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_mask_next  = bank_mask;
                        w_addr_next  = '0;
                        w_state_next = (|bank_mask) ? S_FETCH : S_DONE;
                    end
                end
                S_FETCH: begin
                    // raddr is already on the bus; rdata lands for the STREAM cycle.
                    w_bank_next  = w_low_bank;
                    w_state_next = S_STREAM;
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (w_has_next) begin
                            w_bank_next = w_next_bank;
                        end else if (r_addr == LAST_ADDR) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_addr_next  = r_addr + VID_ADDR_SPACE'(1);
                            w_state_next = S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign vid_sram_raddr = r_addr;
    assign out_addr       = r_addr;
    assign out_bank       = r_bank;
    assign out_valid      = (r_state == S_STREAM);
    assign out_data       = w_words[r_bank];
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);

`ifdef VID_DUMP_CHKSUM_EN
    logic [WORD_W-1:0] r_chksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chksum <= '0;
        end else if (!abort) begin
            if (r_state == S_IDLE && start) begin
                r_chksum <= '0;
            end else if (r_state == S_STREAM && out_ready) begin
                r_chksum <= r_chksum ^ out_data;
            end
        end
    end

    assign chksum = r_chksum;
`endif

endmodule

// File: tb/tb_vid_sram_dump_ctrl.sv
// Scoreboard bench for vid_sram_dump_ctrl: stimulus queues expected words, a negedge monitor checks them.
module tb_vid_sram_dump_ctrl;

    localparam int K      = 16;
    localparam int Q      = 16;
    localparam int VID_BW = 16;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int WW     = Q * VID_BW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [K-1:0]      bank_mask = '0;
    logic [AW-1:0]     vid_sram_raddr;
    logic [K*WW-1:0]   rdata_all;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WW-1:0]     out_data;
    logic [3:0]        out_bank;
    logic [AW-1:0]     out_addr;
    logic              busy;
    logic              done;
`ifdef VID_DUMP_CHKSUM_EN
    logic [WW-1:0]     chksum;
`endif

    vid_sram_dump_ctrl #(.K(K), .Q(Q), .VID_BW(VID_BW), .VID_ADDR_SPACE(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .bank_mask(bank_mask),
        .vid_sram_raddr(vid_sram_raddr),
        .rdata_all(rdata_all),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_bank(out_bank),
        .out_addr(out_addr),
        .busy(busy),
        .done(done)
`ifdef VID_DUMP_CHKSUM_EN
        ,
        .chksum(chksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank b, address a holds Q lanes of {b, a}; bank 0 therefore holds {Q{a}}.
    function automatic logic [WW-1:0] word_of(int b, int a);
        logic [15:0] lane;
        lane = {8'(b), 8'(a)};
        return {Q{lane}};
    endfunction

    // Synchronous-read SRAM banks.
    logic [WW-1:0] rdata_q [K];
    always @(posedge clk) begin
        for (int b = 0; b < K; b++) rdata_q[b] <= word_of(b, int'(vid_sram_raddr));
    end
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_rd
            assign rdata_all[gi*WW +: WW] = rdata_q[gi];
        end
    endgenerate

    typedef struct packed {
        logic [3:0]    bank;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int t0       = 0;
    bit tog_en   = 0;

    function automatic void chk(string name, logic [271:0] act, logic [271:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endfunction

    // Monitor: pop on every handshake, and require held outputs while ready is low.
    bit            hold = 0;
    exp_t          held;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 0;
        end else begin
            if (hold)
                chk("hold_stable", {out_valid, out_bank, out_addr, out_data},
                    {1'b1, held.bank, held.addr, held.data});
            hold = 0;
            if (out_valid && !abort) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {out_bank, out_addr, out_data}, '0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("word", {out_bank, out_addr, out_data}, e);
                        $display("word bank=%0d addr=%0d data=%0h", out_bank, out_addr, out_data[15:0]);
                    end
                end else begin
                    hold = 1;
                    held = '{bank: out_bank, addr: out_addr, data: out_data};
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) out_ready = ~out_ready;
        end
    end

    task automatic push_dump(logic [K-1:0] mask);
        for (int a = 0; a < DEPTH; a++)
            for (int b = 0; b < K; b++)
                if (mask[b]) exp_q.push_back('{bank: 4'(b), addr: AW'(a), data: word_of(b, a)});
    endtask

    task automatic pulse_start(logic [K-1:0] mask);
        @(posedge clk);
        #1;
        bank_mask = mask;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(string name, int budget, int req_lat);
        int lat;
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (req_lat >= 0) chk({name, "_done_latency"}, 272'(lat), 272'(req_lat));
        else              chk({name, "_done_seen"}, 272'(lat >= 0), 272'(1));
        @(posedge clk);
        #1;
        chk({name, "_done_one_cycle"}, 272'(done), 272'(0));
        chk({name, "_idle_after"}, 272'(busy), 272'(0));
        chk({name, "_sb_empty"}, 272'(exp_q.size()), 272'(0));
        $display("%s done latency=%0d", name, lat);
    endtask

    task automatic check_reset_outputs(string name);
        chk({name, "_outs"}, {out_valid, busy, done, vid_sram_raddr, out_bank, out_addr}, '0);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;

        // 1: bank 0 only, ready always high
        push_dump(16'h0001);
        pulse_start(16'h0001);
        wait_done("t1", 200, 32);
`ifdef VID_DUMP_CHKSUM_EN
        chk("t1_chksum", 272'(chksum), 272'(0));
`endif

        // 2: banks 0 and 15
        push_dump(16'h8001);
        pulse_start(16'h8001);
        wait_done("t2", 300, 48);

        // 3: all banks, toggling ready
        push_dump(16'hFFFF);
        tog_en = 1;
        pulse_start(16'hFFFF);
        wait_done("t3", 2000, -1);
        tog_en = 0;
        out_ready = 1'b1;

        // 4: empty mask
        pulse_start(16'h0000);
        wait_done("t4", 20, 0);

        // 5: abort while word 5 is presented, then a fresh dump
        push_dump(16'h0001);
        pulse_start(16'h0001);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid && out_addr == AW'(5)) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("t5_word5_seen", 272'(seen), 272'(1));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t5_abort_outs", {out_valid, busy}, '0);
        exp_q.delete();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            @(posedge clk);
            #1;
        end
        chk("t5_no_done", 272'(seen), 272'(0));
        push_dump(16'h0001);
        pulse_start(16'h0001);
        wait_done("t5b", 200, 32);

        // 6: start while busy is ignored, then reset mid-dump
        push_dump(16'h0001);
        pulse_start(16'h0001);
        repeat (6) @(posedge clk);
        #1;
        bank_mask = 16'hFFFF;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy || done) seen++;
        end
        chk("t6_idle_after_reset", 272'(seen), 272'(0));
        chk("t6_sb_empty", 272'(exp_q.size()), 272'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
